// File: rtl/prng_multi_lane_pkg.sv
// Shared types and lane-slicing helpers for the multi-lane PRNG.
package prng_multi_lane_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_prng_ml_state;

  // Low bit index of lane k inside the packed output word.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

  // High bit index of lane k inside the packed output word.
  function automatic int lane_hi(input int k, input int width);
    return (k * width) + width - 1;
  endfunction

endpackage

// File: rtl/prng_multi_lane_lane.sv
// One Fibonacci LFSR lane: stored seed and taps plus the live state.
// A zero seed is replaced by 1 so the register can never lock up at zero.
module lfsr_lane #(
  parameter int                    DATA_WIDTH   = 49,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TAPS = DATA_WIDTH'(49'h1_0080_0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_taps,
  input  logic                  reload,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] seed;
  logic [DATA_WIDTH-1:0] taps;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [DATA_WIDTH-1:0] seed_fix;
  logic [DATA_WIDTH-1:0] next_word;

  assign seed_fix  = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;
  assign next_word = {data_p0[DATA_WIDTH-2:0], ^(data_p0 & taps)};
  assign word      = data_p0;

  // Seed/taps storage and live state: reload beats config beats step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed    <= DATA_WIDTH'(1);
      taps    <= DEFAULT_TAPS;
      data_p0 <= DATA_WIDTH'(1);
    end else if (reload) begin
      data_p0 <= seed;
    end else if (cfg_we) begin
      seed    <= seed_fix;
      taps    <= cfg_taps;
      data_p0 <= seed_fix;
    end else if (step) begin
      data_p0 <= next_word;
    end
  end

endmodule

// File: rtl/prng_multi_lane.sv
// Multi-lane PRNG: NUM_LANES independent LFSRs stepping together behind a
// valid/ready handshake, terminated by a stop code on lane 0 or a word limit.
module prng_multi_lane
  import prng_multi_lane_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 49,
  parameter int                    NUM_LANES    = 4,
  parameter int                    CNT_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TAPS = DATA_WIDTH'(49'h1_0080_0000_0000),
  parameter int                    LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cfg_vld,
  input  logic [LANE_W-1:0]               i_cfg_lane,
  input  logic [DATA_WIDTH-1:0]           i_cfg_seed,
  input  logic [DATA_WIDTH-1:0]           i_cfg_taps,
  input  logic                            i_start,
  input  logic                            i_clear,
  input  logic [DATA_WIDTH-1:0]           i_stop_code,
  input  logic [CNT_WIDTH-1:0]            i_max_cnt,
  input  logic                            i_rdy,
  output logic                            o_vld,
  output logic [NUM_LANES*DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]            o_cnt,
  output logic                            o_done
);

  st_prng_ml_state state, state_nxt;

  logic [NUM_LANES*DATA_WIDTH-1:0] data_p0;
  logic [CNT_WIDTH-1:0]            cnt;
  logic [CNT_WIDTH-1:0]            cnt_inc;
  logic                            vld_p0;
  logic                            accept;
  logic                            stop_hit;
  logic                            max_hit;
  logic                            term;
  logic                            cfg_hit;

  assign accept   = vld_p0 & i_rdy;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign stop_hit = (data_p0[DATA_WIDTH-1:0] == i_stop_code);
  assign max_hit  = (i_max_cnt != '0) && (cnt_inc == i_max_cnt);
  assign term     = accept & (stop_hit | max_hit);
  assign cfg_hit  = i_cfg_vld && (state == IDLE) && !i_clear &&
                    ({{(32-LANE_W){1'b0}}, i_cfg_lane} < 32'(NUM_LANES));

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lfsr_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEFAULT_TAPS(DEFAULT_TAPS)
    ) u_lane (
      .clk     (i_clk),
      .rst     (i_rst),
      .cfg_we  (cfg_hit && (i_cfg_lane == LANE_W'(k))),
      .cfg_seed(i_cfg_seed),
      .cfg_taps(i_cfg_taps),
      .reload  (i_clear),
      .step    (accept),
      .word    (data_p0[lane_hi(k, DATA_WIDTH):lane_lo(k, DATA_WIDTH)])
    );
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: clear dominates start and every other transition.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = RUN;
        RUN:     if (term)    state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: valid exactly in RUN, done exactly in DONE.
  always_comb begin
    vld_p0 = 1'b0;
    o_done = 1'b0;
    case (state)
      RUN:     vld_p0 = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  // Accepted-word counter, saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      cnt <= '0;
    else if (i_clear)               cnt <= '0;
    else if (accept && cnt != '1)   cnt <= cnt_inc;
  end

  assign o_vld  = vld_p0;
  assign o_data = data_p0;
  assign o_cnt  = cnt;

endmodule

// File: tb/tb_prng_multi_lane.sv
// Directed bench for prng_multi_lane with DATA_WIDTH=8, NUM_LANES=2.
module tb_prng_multi_lane;

  localparam int DW = 8;
  localparam int NL = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_vld;
  logic [0:0]    cfg_lane;
  logic [DW-1:0] cfg_seed;
  logic [DW-1:0] cfg_taps;
  logic          start;
  logic          clear;
  logic [DW-1:0] stop_code;
  logic [CW-1:0] max_cnt;
  logic          rdy;
  logic          vld;
  logic [NL*DW-1:0] data;
  logic [CW-1:0] cnt;
  logic          done;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] seq0 [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
  logic [7:0] seq1 [3] = '{8'h01, 8'h02, 8'h04};

  always #5 clk = ~clk;

  prng_multi_lane #(
    .DATA_WIDTH  (DW),
    .NUM_LANES   (NL),
    .CNT_WIDTH   (CW),
    .DEFAULT_TAPS(8'hB8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_vld  (cfg_vld),
    .i_cfg_lane (cfg_lane),
    .i_cfg_seed (cfg_seed),
    .i_cfg_taps (cfg_taps),
    .i_start    (start),
    .i_clear    (clear),
    .i_stop_code(stop_code),
    .i_max_cnt  (max_cnt),
    .i_rdy      (rdy),
    .o_vld      (vld),
    .o_data     (data),
    .o_cnt      (cnt),
    .o_done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic lane, input logic [DW-1:0] seed, input logic [DW-1:0] taps);
    cfg_vld  = 1'b1;
    cfg_lane = lane;
    cfg_seed = seed;
    cfg_taps = taps;
    tick();
    cfg_vld  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; cfg_lane = '0; cfg_seed = '0; cfg_taps = '0;
    start = 1'b0; clear = 1'b0; stop_code = 8'h00; max_cnt = '0; rdy = 1'b1;
    #1;
    chk("rst_vld",  {31'd0, vld},  32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt",  {16'd0, cnt},  32'd0);
    chk("rst_data", {16'd0, data}, 32'h0101);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Configure lanes; config visible one cycle later, zero seed becomes 1.
    cfg(1'b0, 8'hFF, 8'hB8);
    chk("cfg_l0", {24'd0, data[7:0]}, 32'hFF);
    cfg(1'b1, 8'h00, 8'hB8);
    chk("cfg_l1_zero", {24'd0, data[15:8]}, 32'h01);

    // Free-running sequence; a cfg write mid-run must not disturb lane 1.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq0_%0d", i), {24'd0, data[7:0]}, {24'd0, seq0[i]});
      if (i < 3) chk($sformatf("seq1_%0d", i), {24'd0, data[15:8]}, {24'd0, seq1[i]});
      chk($sformatf("seq_vld_%0d", i), {31'd0, vld}, 32'd1);
      if (i == 1) begin
        cfg_vld = 1'b1; cfg_lane = 1'b1; cfg_seed = 8'h55; cfg_taps = 8'h00;
      end
      tick();
      cfg_vld = 1'b0;
    end
    chk("seq_cnt", {16'd0, cnt}, 32'd6);
    pulse_clear();
    chk("clr_vld",  {31'd0, vld},  32'd0);
    chk("clr_cnt",  {16'd0, cnt},  32'd0);
    chk("clr_data", {16'd0, data}, 32'h01FF);

    // Stop code F8: four words delivered, then DONE.
    stop_code = 8'hF8;
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    chk("stop_last", {24'd0, data[7:0]}, 32'hF8);
    chk("stop_last_vld", {31'd0, vld}, 32'd1);
    tick();
    chk("stop_vld",  {31'd0, vld},  32'd0);
    chk("stop_done", {31'd0, done}, 32'd1);
    chk("stop_cnt",  {16'd0, cnt},  32'd4);
    pulse_start();
    chk("done_start_ign", {31'd0, done}, 32'd1);
    pulse_clear();
    chk("done_clr", {31'd0, done}, 32'd0);
    chk("done_clr_data", {16'd0, data}, 32'h01FF);

    // Word limit 3 with unreachable stop code.
    stop_code = 8'h00;
    max_cnt   = 16'd3;
    pulse_start();
    tick(); tick();
    chk("max_mid_vld", {31'd0, vld}, 32'd1);
    chk("max_mid_cnt", {16'd0, cnt}, 32'd2);
    tick();
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_cnt",  {16'd0, cnt},  32'd3);
    tick();
    chk("max_hold", {24'd0, data[7:0]}, 32'hF8);
    max_cnt = '0;
    pulse_clear();

    // Backpressure: word holds while ready is low.
    rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    chk("bp_data", {24'd0, data[7:0]}, 32'hFF);
    chk("bp_cnt",  {16'd0, cnt},       32'd0);
    rdy = 1'b1;
    tick();
    chk("bp_rel", {24'd0, data[7:0]}, 32'hFE);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("clr_beats_start", {31'd0, vld}, 32'd0);

    // Asynchronous reset in the middle of a run.
    pulse_start();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_vld",  {31'd0, vld},  32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_data", {16'd0, data}, 32'h0101);
    chk("arst_cnt",  {16'd0, cnt},  32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/prng_multi_lane.md
# prng_multi_lane

Multi-lane, parametrised successor to the single-channel pseudo-random generator. It runs NUM_LANES independent Fibonacci LFSRs, each with a run-time seed and tap mask, behind a valid/ready output handshake. Generation terminates on a stop code or a word count. It sits between the test-mode controller and the systolic-array operand feeders: one lane per feeder column.

## Interface
- DATA_WIDTH, 49, bits per lane word (func-1, x-16, y-16, z-16).
- NUM_LANES, 4, number of independent LFSR lanes (≥1).
- CNT_WIDTH, 16, width of the word counter and max-count register.
- DEFAULT_TAPS, 49'h1_0080_0000_0000, tap mask applied to every lane at reset.
- LANE_W, derived, max(1, $clog2(NUM_LANES)).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_cfg_vld  in  1  load seed and taps into lane i_cfg_lane.
- i_cfg_lane  in  LANE_W  target lane.
- i_cfg_seed  in  DATA_WIDTH  seed.
- i_cfg_taps  in  DATA_WIDTH  feedback tap mask.
- i_start  in  1  pulse; begin generation.
- i_clear  in  1  pulse; abort and return to IDLE.
- i_stop_code  in  DATA_WIDTH  terminating word, compared on lane 0.
- i_max_cnt  in  CNT_WIDTH  word limit; 0 means unlimited.
- i_rdy  in  1  downstream ready.
- o_vld  out  1  o_data valid.
- o_data  out  NUM_LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_cnt  out  CNT_WIDTH  words accepted since start.
- o_done  out  1  generation finished.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on i_start.
  - RUN→DONE on the terminating accept.
  - Any state→IDLE on i_clear.
  - DONE holds until i_clear.
- Per lane, step: next = {lane[DATA_WIDTH-2:0], ^(lane & taps)}. A lane steps only on accept (o_vld & i_rdy). All lanes step together.
- Config:
  - Accepted only in IDLE. Ignored in RUN and DONE.
  - Ignored when i_cfg_lane ≥ NUM_LANES.
  - Writes the lane's stored seed, stored taps and live state.
  - A zero seed is stored as 1, which prevents lock-up.
- First word after start is the seeds themselves.
- Terminating accept: either lane 0 word == i_stop_code, or i_max_cnt≠0 and o_cnt+1 == i_max_cnt. The terminating word itself is delivered.
- i_clear: state→IDLE, o_cnt→0, every live lane reloads its stored seed. Taps are kept.
- i_clear and i_start in the same cycle: i_clear wins.
- i_start outside IDLE is ignored.
- o_cnt increments per accept and saturates at all-ones.
- i_stop_code and i_max_cnt are sampled live. They must be held stable during RUN.

## Timing
- Reset values:
  - state IDLE; o_vld 0; o_done 0; o_cnt 0.
  - every lane state and seed = 1; taps = DEFAULT_TAPS.
  - o_data = replicated 1s pattern (each lane = 1).
- i_start at cycle N: o_vld=1 from cycle N+1.
- o_vld=1 exactly in RUN. o_data is registered, with no combinational path from i_rdy.
- With o_vld=1 and i_rdy=0, o_data holds stable.
- Accept at cycle M: new word visible at M+1.
- Terminating accept at M: o_vld=0 and o_done=1 from M+1.
- o_done=1 exactly in DONE.
- Config write at cycle C is visible on o_data at C+1.
- i_rst mid-RUN: all outputs return to their reset values immediately. Configured seeds and taps are lost.

## Structure
- Package prng_multi_lane_pkg holds:
  - typedef enum st_prng_ml_state {IDLE, RUN, DONE};
  - localparam functions for the lane slice index.
- Sub-module lfsr_lane (one per lane, via generate) holds:
  - seed, taps and state registers;
  - the cfg-write, reload and step enables;
  - zero-seed substitution.
- Top level holds the FSM, the counter, stop/max compare and the handshake.

## Test plan
All scenarios use DATA_WIDTH=8, NUM_LANES=2.
- Lane 0 seed 8'hFF, taps 8'hB8, i_rdy=1, start → o_data[7:0] = FF, FE, FC, F8, F0, E1 on consecutive cycles.
- Same config plus i_stop_code=8'hF8 → four words delivered, then o_vld=0, o_done=1, o_cnt=4.
- i_max_cnt=3, stop code unreachable → exactly 3 accepts, then DONE with o_cnt=3.
- i_rdy=0 for 5 cycles after the first word → o_data holds FF and o_cnt stays 0. Release → FE on the next cycle.
- Lane 1 seed 8'h00, taps 8'hB8 → lane 1 outputs 01, 02, 04. Cfg write during RUN → no effect on the sequence.
- Clear and reset:
  - i_clear in DONE → IDLE, o_cnt=0, o_data = stored seeds; restart reproduces the same sequence.
  - i_rst asserted mid-RUN → o_vld=0, o_done=0, lanes = 01.
